// File: rtl/ahb_interconnect.sv
// ahb_interconnect: parametrised AHB-Lite fabric, one master to SLAVE_NUM slaves.
// Decodes HADDR into a one-hot HSEL_o and registers the selection into the data
// phase so that the response mux follows the bus pipeline. Unmapped active
// transfers are answered by a built-in default slave with the two-cycle ERROR
// response, and each one is counted in a saturating 8-bit counter.
//
// Optional feature macro: AHB_ICON_TIMEOUT_EN
//   If defined, a mapped active transfer stalled for TIMEOUT_CYCLES cycles is
//   abandoned and the master receives the two-cycle ERROR response instead.
//
// Ports:
//   HCLK, HRST      clock, synchronous active-high reset
//   HADDR, HTRANS   master address phase
//   HSEL_o          one-hot slave select (combinational, address phase)
//   HRDATA_s        flattened slave read data, slave i at [i*DATA_WIDTH +: DATA_WIDTH]
//   HREADYOUT_s     slave ready outputs
//   HRESP_s         slave responses (1 = ERROR)
//   HRDATA, HREADY, HRESP  data-phase response to the master (HREADY also to slaves)
//   decode_err_cnt  saturating count of unmapped active transfers
module ahb_interconnect #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned SLAVE_NUM      = 4,
  parameter int unsigned REGION_BITS    = 10,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                            HCLK,
  input  logic                            HRST,
  input  logic [ADDR_WIDTH-1:0]           HADDR,
  input  logic [1:0]                      HTRANS,
  output logic [SLAVE_NUM-1:0]            HSEL_o,
  input  logic [SLAVE_NUM*DATA_WIDTH-1:0] HRDATA_s,
  input  logic [SLAVE_NUM-1:0]            HREADYOUT_s,
  input  logic [SLAVE_NUM-1:0]            HRESP_s,
  output logic [DATA_WIDTH-1:0]           HRDATA,
  output logic                            HREADY,
  output logic                            HRESP,
  output logic [7:0]                      decode_err_cnt
);

  localparam int unsigned SEL_W  = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1;
  localparam int unsigned SEL_W1 = SEL_W + 1;

  typedef enum logic [1:0] {
    DS_OK   = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  ds_state_e              ds_state_q;
  logic                   dmap_q;      // data phase owned by a mapped slave (else default slave)
  logic [SEL_W-1:0]       dsel_q;
  logic                   dact_q;

  logic [SEL_W-1:0]       addr_idx;
  logic                   addr_upper_nz;
  logic                   addr_mapped;
  logic                   addr_active;
  logic [DATA_WIDTH-1:0]  slv_rdata;
  logic                   slv_ready;
  logic                   slv_resp;
  logic                   timeout_hit_c;

  // Address-phase decode
  assign addr_idx      = HADDR[REGION_BITS +: SEL_W];
  assign addr_upper_nz = |(HADDR >> (REGION_BITS + SEL_W));
  assign addr_mapped   = !addr_upper_nz && ({1'b0, addr_idx} < SEL_W1'(SLAVE_NUM));
  assign addr_active   = (HTRANS == 2'b10) || (HTRANS == 2'b11);

  // One-hot select, independent of HTRANS
  always_comb begin
    HSEL_o = '0;
    for (int unsigned i = 0; i < SLAVE_NUM; i++) begin
      if (addr_mapped && (addr_idx == SEL_W'(i))) begin
        HSEL_o[i] = 1'b1;
      end
    end
  end

  // Data-phase slave response mux
  always_comb begin
    slv_rdata = '0;
    slv_ready = 1'b1;
    slv_resp  = 1'b0;
    for (int unsigned i = 0; i < SLAVE_NUM; i++) begin
      if (dsel_q == SEL_W'(i)) begin
        slv_rdata = HRDATA_s[i*DATA_WIDTH +: DATA_WIDTH];
        slv_ready = HREADYOUT_s[i];
        slv_resp  = HRESP_s[i];
      end
    end
  end

  // Master response: an error state overrides everything (covers the timeout case)
  always_comb begin
    HRDATA = '0;
    HREADY = 1'b1;
    HRESP  = 1'b0;
    case (ds_state_q)
      DS_ERR1: begin
        HREADY = 1'b0;
        HRESP  = 1'b1;
      end
      DS_ERR2: begin
        HRESP  = 1'b1;
      end
      default: begin
        if (dmap_q) begin
          HRDATA = slv_rdata;
          HREADY = slv_ready;
          HRESP  = slv_resp;
        end
      end
    endcase
  end

`ifdef AHB_ICON_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_q;
  logic [TO_W-1:0] to_cnt_d;
  logic            stalling;

  assign stalling = (ds_state_q == DS_OK) && dmap_q && dact_q && !slv_ready;

  // Stall counter; clears whenever the selected slave is ready or the timeout fires
  always_comb begin
    to_cnt_d      = '0;
    timeout_hit_c = 1'b0;
    if (stalling) begin
      if ((to_cnt_q + TO_W'(1)) == TO_W'(TIMEOUT_CYCLES)) begin
        timeout_hit_c = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRST) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  // No stall limit: TIMEOUT_CYCLES has no effect in this build
  assign timeout_hit_c = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

  // Data-phase registers, default-slave FSM and decode-error counter
  always_ff @(posedge HCLK) begin
    if (HRST) begin
      dmap_q         <= 1'b0;
      dsel_q         <= '0;
      dact_q         <= 1'b0;
      ds_state_q     <= DS_OK;
      decode_err_cnt <= 8'd0;
    end else begin
      if (HREADY) begin
        dmap_q <= addr_mapped;
        dsel_q <= addr_idx;
        dact_q <= addr_active;
      end
      case (ds_state_q)
        DS_OK: begin
          if (timeout_hit_c) begin
            ds_state_q <= DS_ERR1;
          end else if (HREADY && !addr_mapped && addr_active) begin
            ds_state_q <= DS_ERR1;
            if (decode_err_cnt != 8'hFF) decode_err_cnt <= decode_err_cnt + 8'd1;
          end
        end
        DS_ERR1: ds_state_q <= DS_ERR2;
        DS_ERR2: begin
          // HREADY is 1 here, so this cycle always loads the next address
          if (!addr_mapped && addr_active) begin
            ds_state_q <= DS_ERR1;
            if (decode_err_cnt != 8'hFF) decode_err_cnt <= decode_err_cnt + 8'd1;
          end else begin
            ds_state_q <= DS_OK;
          end
        end
        default: ds_state_q <= DS_OK;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_interconnect.sv
// Self-checking bench for ahb_interconnect (4 slaves, 1 KiB regions).
module tb_ahb_interconnect;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned NS = 4;
  localparam int unsigned RB = 10;
  localparam int unsigned TO = 16;

  logic             HCLK = 1'b0;
  logic             HRST;
  logic [AW-1:0]    HADDR;
  logic [1:0]       HTRANS;
  logic [NS-1:0]    HSEL_o;
  logic [NS*DW-1:0] HRDATA_s;
  logic [NS-1:0]    HREADYOUT_s;
  logic [NS-1:0]    HRESP_s;
  logic [DW-1:0]    HRDATA;
  logic             HREADY;
  logic             HRESP;
  logic [7:0]       decode_err_cnt;

  int vectors     = 0;
  int miscompares = 0;
  int exp_cnt     = 0;

  ahb_interconnect #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SLAVE_NUM(NS),
    .REGION_BITS(RB), .TIMEOUT_CYCLES(TO)
  ) dut (
    .HCLK(HCLK), .HRST(HRST), .HADDR(HADDR), .HTRANS(HTRANS), .HSEL_o(HSEL_o),
    .HRDATA_s(HRDATA_s), .HREADYOUT_s(HREADYOUT_s), .HRESP_s(HRESP_s),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .decode_err_cnt(decode_err_cnt)
  );

  always #5 HCLK = ~HCLK;

  // Reference: the map is simply [0, NS * 2^RB); slave = address / 2^RB
  function automatic bit is_mapped(input logic [AW-1:0] a);
    return 64'(a) < (64'(NS) * 64'(1 << RB));
  endfunction

  function automatic logic [NS-1:0] exp_sel(input logic [AW-1:0] a);
    logic [NS-1:0] r;
    r = '0;
    if (is_mapped(a)) r[a / (1 << RB)] = 1'b1;
    return r;
  endfunction

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic quiet_slaves();
    HRDATA_s    = '0;
    HREADYOUT_s = '1;
    HRESP_s     = '0;
  endtask

  task automatic set_slave(input int s, input logic [DW-1:0] d, input logic rdy, input logic rsp);
    HRDATA_s[s*DW +: DW] = d;
    HREADYOUT_s[s]       = rdy;
    HRESP_s[s]           = rsp;
  endtask

  task automatic test_reset();
    HRST = 1'b1; HADDR = '0; HTRANS = 2'b00; quiet_slaves();
    tick(); tick();
    #1;
    vectors++; if (HREADY !== 1'b1) begin miscompares++; $display("FAIL reset_hready got %b exp 1", HREADY); end
    vectors++; if (HRESP !== 1'b0) begin miscompares++; $display("FAIL reset_hresp got %b exp 0", HRESP); end
    vectors++; if (HRDATA !== '0) begin miscompares++; $display("FAIL reset_hrdata got %h exp 0", HRDATA); end
    vectors++; if (decode_err_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_cnt got %0d exp 0", decode_err_cnt); end
    HADDR = 32'h0000_0804;
    #1;
    vectors++; if (HSEL_o !== 4'b0100) begin miscompares++; $display("FAIL reset_hsel got %b exp 0100", HSEL_o); end
    HRST = 1'b0; HADDR = '0; exp_cnt = 0;
  endtask

  task automatic test_mapped_read();
    quiet_slaves();
    HADDR = 32'h0000_0804; HTRANS = 2'b10;
    #1;
    vectors++; if (HSEL_o !== 4'b0100) begin miscompares++; $display("FAIL rd_hsel got %b exp 0100", HSEL_o); end
    tick();
    HADDR = '0; HTRANS = 2'b00;
    set_slave(2, 32'hDEAD_BEEF, 1'b1, 1'b0);
    set_slave(1, 32'h1111_1111, 1'b0, 1'b1);
    #1;
    vectors++; if (HRDATA !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL rd_data got %h exp deadbeef", HRDATA); end
    vectors++; if (HREADY !== 1'b1) begin miscompares++; $display("FAIL rd_hready got %b exp 1", HREADY); end
    vectors++; if (HRESP !== 1'b0) begin miscompares++; $display("FAIL rd_hresp got %b exp 0", HRESP); end
    tick();
    quiet_slaves();
  endtask

  task automatic test_unmapped();
    quiet_slaves();
    HADDR = 32'h0000_1000; HTRANS = 2'b10;
    #1;
    vectors++; if (HSEL_o !== 4'b0000) begin miscompares++; $display("FAIL um_hsel got %b exp 0000", HSEL_o); end
    tick();
    exp_cnt++;
    HADDR = '0; HTRANS = 2'b00;
    #1;
    vectors++; if ({HREADY, HRESP} !== 2'b01) begin miscompares++; $display("FAIL um_err1 got %b%b exp 01", HREADY, HRESP); end
    vectors++; if (HRDATA !== '0) begin miscompares++; $display("FAIL um_hrdata got %h exp 0", HRDATA); end
    vectors++; if (decode_err_cnt !== 8'(exp_cnt)) begin miscompares++; $display("FAIL um_cnt got %0d exp %0d", decode_err_cnt, exp_cnt); end
    tick();
    vectors++; if ({HREADY, HRESP} !== 2'b11) begin miscompares++; $display("FAIL um_err2 got %b%b exp 11", HREADY, HRESP); end
    tick();
    vectors++; if ({HREADY, HRESP} !== 2'b10) begin miscompares++; $display("FAIL um_after got %b%b exp 10", HREADY, HRESP); end
  endtask

  task automatic test_unmapped_idle();
    quiet_slaves();
    for (int t = 0; t < 2; t++) begin
      HADDR = 32'hFFFF_0000; HTRANS = 2'(t);
      #1;
      vectors++; if (HSEL_o !== 4'b0000) begin miscompares++; $display("FAIL ui_hsel got %b exp 0000", HSEL_o); end
      tick();
      HADDR = '0; HTRANS = 2'b00;
      #1;
      vectors++; if ({HREADY, HRESP} !== 2'b10) begin miscompares++; $display("FAIL ui_resp trans=%0d got %b%b exp 10", t, HREADY, HRESP); end
      vectors++; if (decode_err_cnt !== 8'(exp_cnt)) begin miscompares++; $display("FAIL ui_cnt got %0d exp %0d", decode_err_cnt, exp_cnt); end
    end
  endtask

  task automatic test_wait_pipeline();
    quiet_slaves();
    HADDR = 32'h0000_0400; HTRANS = 2'b10;
    tick();
    HADDR = 32'h0000_0C00; HTRANS = 2'b10;
    for (int c = 0; c < 3; c++) begin
      set_slave(1, 32'h0101_0101, 1'b0, 1'b0);
      set_slave(3, 32'h0303_0303, 1'b1, 1'b1);
      #1;
      vectors++; if (HREADY !== 1'b0) begin miscompares++; $display("FAIL wp_wait c=%0d got %b exp 0", c, HREADY); end
      vectors++; if (HSEL_o !== 4'b1000) begin miscompares++; $display("FAIL wp_hsel c=%0d got %b exp 1000", c, HSEL_o); end
      tick();
    end
    set_slave(1, 32'hA5A5_0001, 1'b1, 1'b0);
    #1;
    vectors++; if ({HREADY, HRESP, HRDATA} !== {2'b10, 32'hA5A5_0001}) begin miscompares++; $display("FAIL wp_s1_done got %b%b %h exp 10 a5a50001", HREADY, HRESP, HRDATA); end
    tick();
    HADDR = '0; HTRANS = 2'b00;
    set_slave(1, 32'hBAD0_BAD0, 1'b0, 1'b1);
    set_slave(3, 32'h3333_C0DE, 1'b1, 1'b0);
    #1;
    vectors++; if ({HREADY, HRESP, HRDATA} !== {2'b10, 32'h3333_C0DE}) begin miscompares++; $display("FAIL wp_s3_done got %b%b %h exp 10 3333c0de", HREADY, HRESP, HRDATA); end
    tick();
    quiet_slaves();
  endtask

  task automatic test_back_to_back();
    quiet_slaves();
    HADDR = 32'h0000_0800; HTRANS = 2'b10;
    tick();
    HADDR = 32'h0000_2000; HTRANS = 2'b10;
    set_slave(2, 32'h2222_0000, 1'b0, 1'b0);
    #1;
    vectors++; if (HREADY !== 1'b0) begin miscompares++; $display("FAIL bb_wait got %b exp 0", HREADY); end
    tick();
    set_slave(2, 32'h2222_ABCD, 1'b1, 1'b0);
    #1;
    vectors++; if ({HREADY, HRESP, HRDATA} !== {2'b10, 32'h2222_ABCD}) begin miscompares++; $display("FAIL bb_slave got %b%b %h exp 10 2222abcd", HREADY, HRESP, HRDATA); end
    tick();
    if (exp_cnt < 255) exp_cnt++;
    HADDR = '0; HTRANS = 2'b00;
    #1;
    vectors++; if ({HREADY, HRESP} !== 2'b01) begin miscompares++; $display("FAIL bb_err1 got %b%b exp 01", HREADY, HRESP); end
    vectors++; if (decode_err_cnt !== 8'(exp_cnt)) begin miscompares++; $display("FAIL bb_cnt got %0d exp %0d", decode_err_cnt, exp_cnt); end
    tick();
    vectors++; if ({HREADY, HRESP} !== 2'b11) begin miscompares++; $display("FAIL bb_err2 got %b%b exp 11", HREADY, HRESP); end
    tick();
    quiet_slaves();
  endtask

  task automatic test_long_stall();
    quiet_slaves();
    HADDR = '0; HTRANS = 2'b10;
    tick();
    HADDR = '0; HTRANS = 2'b00;
    set_slave(0, 32'h0000_5A5A, 1'b0, 1'b0);
`ifdef AHB_ICON_TIMEOUT_EN
    for (int c = 0; c < int'(TO); c++) begin
      #1;
      vectors++; if ({HREADY, HRESP} !== 2'b00) begin miscompares++; $display("FAIL to_stall c=%0d got %b%b exp 00", c, HREADY, HRESP); end
      tick();
    end
    vectors++; if ({HREADY, HRESP} !== 2'b01) begin miscompares++; $display("FAIL to_err1 got %b%b exp 01", HREADY, HRESP); end
    vectors++; if (decode_err_cnt !== 8'(exp_cnt)) begin miscompares++; $display("FAIL to_cnt got %0d exp %0d", decode_err_cnt, exp_cnt); end
    tick();
    quiet_slaves();
    #1;
    vectors++; if ({HREADY, HRESP} !== 2'b11) begin miscompares++; $display("FAIL to_err2 got %b%b exp 11", HREADY, HRESP); end
    tick();
    vectors++; if ({HREADY, HRESP} !== 2'b10) begin miscompares++; $display("FAIL to_after got %b%b exp 10", HREADY, HRESP); end
`else
    for (int c = 0; c < 20; c++) begin
      #1;
      vectors++; if ({HREADY, HRESP} !== 2'b00) begin miscompares++; $display("FAIL ls_stall c=%0d got %b%b exp 00", c, HREADY, HRESP); end
      tick();
    end
    set_slave(0, 32'h0000_5A5A, 1'b1, 1'b0);
    #1;
    vectors++; if ({HREADY, HRESP, HRDATA} !== {2'b10, 32'h0000_5A5A}) begin miscompares++; $display("FAIL ls_done got %b%b %h exp 10 00005a5a", HREADY, HRESP, HRDATA); end
    tick();
    quiet_slaves();
`endif
  endtask

  // Transaction-level model: each transfer's data phase lasts (waits+1) cycles if
  // mapped, 2 ERROR cycles if unmapped and active, 1 OKAY cycle otherwise.
  task automatic test_random(input int n);
    logic [AW-1:0] a_q[$];
    logic [1:0]    t_q[$];
    int            w_q[$];
    logic [AW-1:0] a, cur_a, prev_a;
    logic [1:0]    cur_t, prev_t;
    int            r, prev_w, cur_w, ncyc, ps;
    bit            pm, pact;
    logic          rdy, rsp, e_rdy, e_rsp;
    logic [DW-1:0] dat, e_dat;
    for (int k = 0; k < n; k++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6)      a = (AW'($urandom_range(0, NS - 1)) << RB) | AW'($urandom_range(0, (1 << RB) - 1));
      else if (r < 8) a = (AW'(NS) << RB) + AW'($urandom_range(0, 4095));
      else            a = AW'($urandom);
      a_q.push_back(a);
      t_q.push_back(2'($urandom_range(0, 3)));
      w_q.push_back(int'($urandom_range(0, 3)));
    end
    quiet_slaves();
    HADDR = '0; HTRANS = 2'b00;
    tick();
    prev_a = '0; prev_t = 2'b00; prev_w = 0;
    for (int k = 0; k <= n; k++) begin
      cur_a = (k < n) ? a_q[k] : '0;
      cur_t = (k < n) ? t_q[k] : 2'b00;
      cur_w = (k < n && cur_t[1]) ? w_q[k] : 0;
      pm    = is_mapped(prev_a);
      pact  = prev_t[1];
      ncyc  = pm ? prev_w + 1 : (pact ? 2 : 1);
      for (int j = 0; j < ncyc; j++) begin
        HADDR = cur_a; HTRANS = cur_t;
        for (int s = 0; s < int'(NS); s++) begin
          set_slave(s, DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        if (pm) begin
          ps  = int'(prev_a / (1 << RB));
          rdy = (j == prev_w);
          rsp = 1'($urandom_range(0, 1));
          dat = DW'($urandom);
          set_slave(ps, dat, rdy, rsp);
          e_rdy = rdy; e_rsp = rsp; e_dat = dat;
        end else if (pact) begin
          e_rdy = (j == 1); e_rsp = 1'b1; e_dat = '0;
        end else begin
          e_rdy = 1'b1; e_rsp = 1'b0; e_dat = '0;
        end
        #1;
        vectors++; if (HSEL_o !== exp_sel(cur_a)) begin miscompares++; $display("FAIL rnd_hsel k=%0d addr=%h got %b exp %b", k, cur_a, HSEL_o, exp_sel(cur_a)); end
        vectors++; if (HREADY !== e_rdy) begin miscompares++; $display("FAIL rnd_hready k=%0d j=%0d prev=%h got %b exp %b", k, j, prev_a, HREADY, e_rdy); end
        vectors++; if (HRESP !== e_rsp) begin miscompares++; $display("FAIL rnd_hresp k=%0d j=%0d prev=%h got %b exp %b", k, j, prev_a, HRESP, e_rsp); end
        vectors++; if (HRDATA !== e_dat) begin miscompares++; $display("FAIL rnd_hrdata k=%0d j=%0d got %h exp %h", k, j, HRDATA, e_dat); end
        vectors++; if (decode_err_cnt !== 8'(exp_cnt)) begin miscompares++; $display("FAIL rnd_cnt k=%0d got %0d exp %0d", k, decode_err_cnt, exp_cnt); end
        tick();
      end
      if (!is_mapped(cur_a) && cur_t[1] && exp_cnt < 255) exp_cnt++;
      prev_a = cur_a; prev_t = cur_t; prev_w = cur_w;
    end
  endtask

  task automatic test_saturation_reset();
    quiet_slaves();
    HADDR = 32'h0000_1000; HTRANS = 2'b10;
    for (int t = 1; t < 600; t++) begin
      tick();
      if ((t % 2) == 1 && exp_cnt < 255) exp_cnt++;
      vectors++; if ({HREADY, HRESP} !== {((t % 2) == 0), 1'b1}) begin miscompares++; $display("FAIL sat_resp t=%0d got %b%b exp %b1", t, HREADY, HRESP, ((t % 2) == 0)); end
      vectors++; if (decode_err_cnt !== 8'(exp_cnt)) begin miscompares++; $display("FAIL sat_cnt t=%0d got %0d exp %0d", t, decode_err_cnt, exp_cnt); end
    end
    vectors++; if (decode_err_cnt !== 8'd255) begin miscompares++; $display("FAIL sat_final got %0d exp 255", decode_err_cnt); end
    HRST = 1'b1;
    tick();
    HRST = 1'b0; HADDR = '0; HTRANS = 2'b00; exp_cnt = 0;
    #1;
    vectors++; if ({HREADY, HRESP} !== 2'b10) begin miscompares++; $display("FAIL rst_mid_resp got %b%b exp 10", HREADY, HRESP); end
    vectors++; if (HRDATA !== '0) begin miscompares++; $display("FAIL rst_mid_hrdata got %h exp 0", HRDATA); end
    vectors++; if (decode_err_cnt !== 8'd0) begin miscompares++; $display("FAIL rst_mid_cnt got %0d exp 0", decode_err_cnt); end
    tick();
  endtask

  initial begin
    test_reset();
    test_mapped_read();
    test_unmapped();
    test_unmapped_idle();
    test_wait_pipeline();
    test_back_to_back();
    test_long_stall();
    test_random(300);
    test_saturation_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ahb_interconnect.md
Name: ahb_interconnect

Overview:
Parametrised AHB-Lite bus fabric between one master and SLAVE_NUM slaves. It replaces the fixed 4-slave decoder and multiplexor pair, which were driven by an explicit select input.
- Decodes slave select from HADDR in the address phase.
- Registers the select into the data phase, so response muxing is pipeline-correct.
- Contains a built-in default slave that returns the two-cycle ERROR response for unmapped addresses.
- Drives a decode-error counter.

Parameters:
- DATA_WIDTH, 32, HRDATA width per slave.
- ADDR_WIDTH, 32, HADDR width.
- SLAVE_NUM, 4, number of slave ports; 1..16, need not be a power of 2.
- REGION_BITS, 10, log2 of region size; slave i owns [i<<REGION_BITS, (i+1)<<REGION_BITS).
- TIMEOUT_CYCLES, 16, stall limit; used only with AHB_ICON_TIMEOUT_EN.

Ports:
- HCLK  in  1  clock.
- HRST  in  1  synchronous active-high reset.
- HADDR  in  ADDR_WIDTH  master address.
- HTRANS  in  2  master transfer type; IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HSEL_o  out  SLAVE_NUM  one-hot slave select, address phase.
- HRDATA_s  in  SLAVE_NUM*DATA_WIDTH  slave read data, flattened; slave i at [i*DATA_WIDTH +: DATA_WIDTH].
- HREADYOUT_s  in  SLAVE_NUM  slave ready outputs.
- HRESP_s  in  SLAVE_NUM  slave responses; 1 = ERROR.
- HRDATA  out  DATA_WIDTH  read data to master.
- HREADY  out  1  ready to master and broadcast to all slaves.
- HRESP  out  1  response to master.
- decode_err_cnt  out  8  saturating count of unmapped active transfers.

Behaviour:
- SEL_W = max(1, clog2(SLAVE_NUM)). idx = HADDR[REGION_BITS +: SEL_W].
- Address is mapped iff all HADDR bits above REGION_BITS+SEL_W are 0 and idx < SLAVE_NUM.
- HSEL_o is combinational:
  - one-hot bit idx when the address is mapped, regardless of HTRANS;
  - all zeros when unmapped.
- Data-phase registers: dsel (index, or DEF = unmapped) and dact (= HTRANS[1]).
  - Load only on rising HCLK when HREADY=1; hold otherwise.
  - Reset values: dsel=DEF, dact=0.
- Mapped data phase (dsel = slave i): HRDATA = slice i, HREADY = HREADYOUT_s[i], HRESP = HRESP_s[i]. Pure combinational passthrough, zero added latency.
- Default slave FSM, states DS_OK, DS_ERR1, DS_ERR2. Reset state DS_OK.
  - DS_OK -> DS_ERR1 on a load with an unmapped address and HTRANS[1]=1.
  - DS_ERR1 -> DS_ERR2 unconditionally.
  - DS_ERR2 -> DS_ERR1 if the load in this cycle is unmapped and active; otherwise -> DS_OK.
- Default-slave outputs while dsel=DEF:
  - DS_OK: HREADY=1, HRESP=0.
  - DS_ERR1: HREADY=0, HRESP=1.
  - DS_ERR2: HREADY=1, HRESP=1.
  - HRDATA=0 in all three states.
- Unmapped IDLE/BUSY: zero-wait OKAY; no error, no count.
- decode_err_cnt:
  - Increments by 1 on each DS_OK->DS_ERR1 or DS_ERR2->DS_ERR1 transition.
  - Saturates at 255.
  - Reset value 0.
- Reset values of all outputs: HREADY=1, HRESP=0, HRDATA=0, decode_err_cnt=0. HSEL_o follows HADDR combinationally.
- Reset mid-transfer: all state returns to reset values on the next edge; an outstanding slave wait is abandoned.
- Mapped slave to unmapped address back-to-back:
  - The slave's data phase completes first, with HREADY from the slave.
  - The default slave's error starts the cycle after the load.

Optional Feature:
Macro: AHB_ICON_TIMEOUT_EN
- Defined:
  - A counter (width clog2(TIMEOUT_CYCLES+1)) increments each cycle with dsel mapped, dact=1 and HREADYOUT_s[dsel]=0.
  - The counter clears when that HREADYOUT_s is 1 or on reset.
  - When it reaches TIMEOUT_CYCLES, the FSM enters DS_ERR1 and the master gets the two-cycle ERROR override, independent of the slave.
  - The stalled transfer is abandoned.
  - decode_err_cnt is not incremented.
- Undefined: no counter exists; a stalling slave stalls the bus indefinitely.

Test Plan:
All scenarios use SLAVE_NUM=4, REGION_BITS=10.
- Mapped read: HADDR=0x0000_0804, HTRANS=NONSEQ -> HSEL_o=4'b0100. Next cycle, with slave 2 driving 0xDEADBEEF, ready=1 -> HRDATA=0xDEADBEEF, HREADY=1, HRESP=0.
- Unmapped: HADDR=0x0000_1000, NONSEQ -> HSEL_o=0.
  - Cycle 1: HREADY=0, HRESP=1.
  - Cycle 2: HREADY=1, HRESP=1.
  - decode_err_cnt=1.
- Unmapped IDLE: HADDR=0xFFFF_0000, HTRANS=IDLE -> HREADY=1, HRESP=0, count unchanged.
- Wait states and pipelining: slave 1 holds HREADYOUT_s=0 for 3 cycles while the next address is 0x0000_0C00. dsel stays 1 for 3 cycles; slave 3 takes the data phase only after slave 1 is ready.
- Saturation and reset: 300 back-to-back unmapped NONSEQ -> decode_err_cnt=255. Assert HRST for 1 cycle mid-ERR1 -> next cycle HREADY=1, HRESP=0, count=0.
- With AHB_ICON_TIMEOUT_EN and TIMEOUT_CYCLES=16: slave 0 holds ready=0 forever. After 16 stall cycles, ERR1 then ERR2 is seen on HREADY/HRESP; decode_err_cnt is unchanged.
